// File: rtl/keypad_event_encoder_if.sv
// Key-event handshake and status bundle between the keypad encoder and the game core.
interface keypad_event_encoder_if #(
   parameter int unsigned CODE_W = 4
);
   logic              key_valid;
   logic              key_ready;
   logic [CODE_W-1:0] key_code;
   logic              multi_err;
   logic              overflow;
   logic              held;

   modport master (
      output key_valid,
      output key_code,
      output multi_err,
      output overflow,
      output held,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_code,
      input  multi_err,
      input  overflow,
      input  held,
      output key_ready
   );
endinterface

// File: rtl/keypad_event_encoder.sv
// Pushbutton conditioning: synchronise, debounce, reject chords, encode and queue one event
// per press on a valid/ready handshake.
module keypad_event_encoder #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CODE_W   = $clog2(WIDTH),
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       pb_in,
   keypad_event_encoder_if.master key
);

   localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {StIdle, StPressed, StInvalid} state_e;

   logic [WIDTH-1:0]  meta_q, sync_vec, stable_vec, pressed_q, pressed_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              same, load;
   logic              is_zero, is_onehot, is_multi;
   logic [CODE_W-1:0] enc;
   state_e            state_q, state_d;
   logic              press_ev, chord;
   logic              valid_q, multi_q, overflow_q;
   logic [CODE_W-1:0] code_q;

   // cnt tracks run length minus one of the value sync_vec is taking on this edge, so
   // stable_vec updates in step with the second synchroniser flop once DEBOUNCE samples agree.
   always_comb begin
      same  = (meta_q == sync_vec);
      cnt_d = '0;
      if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      load  = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q     <= '0;
         sync_vec   <= '0;
         cnt_q      <= '0;
         stable_vec <= '0;
      end else begin
         meta_q   <= pb_in;
         sync_vec <= meta_q;
         cnt_q    <= cnt_d;
         if (load) stable_vec <= meta_q;
      end
   end

   always_comb begin
      is_zero   = (stable_vec == '0);
      is_onehot = !is_zero && ((stable_vec & (stable_vec - WIDTH'(1))) == '0);
      is_multi  = !is_zero && !is_onehot;
      enc       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (stable_vec[i]) enc = CODE_W'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      pressed_d = pressed_q;
      press_ev  = 1'b0;
      chord     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (is_onehot) begin
               state_d   = StPressed;
               pressed_d = stable_vec;
               press_ev  = 1'b1;
            end else if (is_multi) begin
               state_d = StInvalid;
               chord   = 1'b1;
            end
         end
         StPressed: begin
            if (is_zero) begin
               state_d = StIdle;
            end else if (stable_vec != pressed_q) begin
               state_d = StInvalid;
               chord   = 1'b1;
            end
         end
         StInvalid: begin
            if (is_zero) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         pressed_q  <= '0;
         multi_q    <= 1'b0;
         valid_q    <= 1'b0;
         code_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pressed_q <= pressed_d;
         multi_q   <= chord;
         // A new event may replace the entry only when it is empty or leaving this cycle.
         if (press_ev) begin
            if (!valid_q || key.key_ready) begin
               valid_q <= 1'b1;
               code_q  <= enc;
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (valid_q && key.key_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign key.key_valid = valid_q;
   assign key.key_code  = code_q;
   assign key.multi_err = multi_q;
   assign key.overflow  = overflow_q;
   assign key.held      = (state_q != StIdle);

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder: press, bounce, chord, backpressure, same-cycle
// replace and mid-operation reset.
module tb_keypad_event_encoder;

   logic        clk;
   logic        rst;
   logic [15:0] pb_in;
   int          checks;
   int          errors;
   int          xfers;
   int          multi_cnt;
   int          last_code;
   int          x0;
   int          m0;

   keypad_event_encoder_if #(.CODE_W(4)) key_if ();

   keypad_event_encoder #(
      .WIDTH   (16),
      .CODE_W  (4),
      .DEBOUNCE(3)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .pb_in(pb_in),
      .key  (key_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Consumer-side observer: transfers and chord pulses seen at each active edge.
   always @(posedge clk) begin
      if (rst) begin
         if (key_if.key_valid && key_if.key_ready) begin
            xfers     = xfers + 1;
            last_code = int'(key_if.key_code);
         end
         if (key_if.multi_err) multi_cnt = multi_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      xfers     = 0;
      multi_cnt = 0;
      last_code = -1;
      rst       = 1'b0;
      pb_in     = '0;
      key_if.key_ready = 1'b0;
      wait_cycles(3);
      rst = 1'b1;
      tick();
      check_eq("rst_valid", 32'(key_if.key_valid), 0);
      check_eq("rst_code", 32'(key_if.key_code), 0);
      check_eq("rst_multi", 32'(key_if.multi_err), 0);
      check_eq("rst_ovf", 32'(key_if.overflow), 0);
      check_eq("rst_held", 32'(key_if.held), 0);

      // Single press, consumer always ready
      key_if.key_ready = 1'b1;
      x0 = xfers;
      pb_in = 16'h0010;
      wait_cycles(4);
      check_eq("sp_early_valid", 32'(key_if.key_valid), 0);
      tick();
      check_eq("sp_valid", 32'(key_if.key_valid), 1);
      check_eq("sp_code", 32'(key_if.key_code), 4);
      check_eq("sp_held", 32'(key_if.held), 1);
      tick();
      check_eq("sp_valid_drop", 32'(key_if.key_valid), 0);
      wait_cycles(4);
      pb_in = '0;
      wait_cycles(4);
      check_eq("sp_held_pre_rel", 32'(key_if.held), 1);
      tick();
      check_eq("sp_held_rel", 32'(key_if.held), 0);
      check_eq("sp_one_event", 32'(xfers - x0), 1);
      check_eq("sp_last_code", 32'(last_code), 4);

      // Bounce on bit 0, then a steady press
      x0 = xfers;
      for (int i = 0; i < 6; i++) begin
         pb_in = (i % 2 == 0) ? 16'h0001 : 16'h0000;
         tick();
      end
      pb_in = 16'h0001;
      wait_cycles(4);
      check_eq("bn_no_early", 32'(xfers - x0), 0);
      check_eq("bn_no_held", 32'(key_if.held), 0);
      tick();
      check_eq("bn_valid", 32'(key_if.key_valid), 1);
      check_eq("bn_code", 32'(key_if.key_code), 0);
      wait_cycles(5);
      check_eq("bn_one_event", 32'(xfers - x0), 1);
      check_eq("bn_last_code", 32'(last_code), 0);
      pb_in = '0;
      wait_cycles(8);

      // Chord rejected, then a clean press of bit 15
      x0 = xfers;
      m0 = multi_cnt;
      pb_in = 16'h8001;
      wait_cycles(4);
      check_eq("ch_multi_early", 32'(key_if.multi_err), 0);
      tick();
      check_eq("ch_multi", 32'(key_if.multi_err), 1);
      check_eq("ch_held", 32'(key_if.held), 1);
      tick();
      check_eq("ch_multi_width", 32'(key_if.multi_err), 0);
      wait_cycles(4);
      check_eq("ch_multi_once", 32'(multi_cnt - m0), 1);
      check_eq("ch_no_event", 32'(xfers - x0), 0);
      check_eq("ch_no_valid", 32'(key_if.key_valid), 0);
      pb_in = '0;
      wait_cycles(8);
      check_eq("ch_idle", 32'(key_if.held), 0);
      pb_in = 16'h8000;
      wait_cycles(5);
      check_eq("ch_valid15", 32'(key_if.key_valid), 1);
      check_eq("ch_code15", 32'(key_if.key_code), 15);
      wait_cycles(3);
      check_eq("ch_one_event", 32'(xfers - x0), 1);
      check_eq("ch_last_code", 32'(last_code), 15);
      pb_in = '0;
      wait_cycles(8);

      // Backpressure: second press dropped
      key_if.key_ready = 1'b0;
      x0 = xfers;
      pb_in = 16'h0004;
      wait_cycles(8);
      check_eq("bp_valid", 32'(key_if.key_valid), 1);
      check_eq("bp_code", 32'(key_if.key_code), 2);
      check_eq("bp_ovf0", 32'(key_if.overflow), 0);
      pb_in = '0;
      wait_cycles(8);
      pb_in = 16'h0100;
      wait_cycles(8);
      check_eq("bp_valid_hold", 32'(key_if.key_valid), 1);
      check_eq("bp_code_hold", 32'(key_if.key_code), 2);
      check_eq("bp_ovf1", 32'(key_if.overflow), 1);
      pb_in = '0;
      wait_cycles(8);
      key_if.key_ready = 1'b1;
      tick();
      check_eq("bp_drain", 32'(key_if.key_valid), 0);
      check_eq("bp_one_xfer", 32'(xfers - x0), 1);
      check_eq("bp_xfer_code", 32'(last_code), 2);
      tick();
      check_eq("bp_no_more", 32'(xfers - x0), 1);
      check_eq("bp_ovf_sticky", 32'(key_if.overflow), 1);

      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_eq("rst2_ovf", 32'(key_if.overflow), 0);

      // Event lands on the same cycle as a transfer
      key_if.key_ready = 1'b0;
      pb_in = 16'h0008;
      wait_cycles(8);
      check_eq("sc_valid3", 32'(key_if.key_valid), 1);
      check_eq("sc_code3", 32'(key_if.key_code), 3);
      pb_in = '0;
      wait_cycles(8);
      x0 = xfers;
      pb_in = 16'h0200;
      wait_cycles(4);
      check_eq("sc_code_stable", 32'(key_if.key_code), 3);
      key_if.key_ready = 1'b1;
      tick();
      check_eq("sc_valid", 32'(key_if.key_valid), 1);
      check_eq("sc_code9", 32'(key_if.key_code), 9);
      check_eq("sc_ovf", 32'(key_if.overflow), 0);
      check_eq("sc_xfer3", 32'(last_code), 3);
      tick();
      check_eq("sc_drain", 32'(key_if.key_valid), 0);
      check_eq("sc_xfer9", 32'(last_code), 9);
      check_eq("sc_two_xfers", 32'(xfers - x0), 2);
      pb_in = '0;
      key_if.key_ready = 1'b0;
      wait_cycles(8);

      // Reset while an event is pending, button kept held
      pb_in = 16'h0040;
      wait_cycles(6);
      check_eq("rm_valid", 32'(key_if.key_valid), 1);
      check_eq("rm_code", 32'(key_if.key_code), 6);
      rst = 1'b0;
      #1;
      check_eq("rm_rst_valid", 32'(key_if.key_valid), 0);
      check_eq("rm_rst_code", 32'(key_if.key_code), 0);
      check_eq("rm_rst_held", 32'(key_if.held), 0);
      check_eq("rm_rst_ovf", 32'(key_if.overflow), 0);
      tick();
      rst = 1'b1;
      x0 = xfers;
      wait_cycles(4);
      check_eq("rm_early", 32'(key_if.key_valid), 0);
      tick();
      check_eq("rm_valid_again", 32'(key_if.key_valid), 1);
      check_eq("rm_code_again", 32'(key_if.key_code), 6);
      key_if.key_ready = 1'b1;
      tick();
      check_eq("rm_xfer", 32'(xfers - x0), 1);
      check_eq("rm_xfer_code", 32'(last_code), 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
